// File: rtl/pipe5_hazard_core.sv
// pipe5_hazard_core: 5-stage IF/ID/EX/MEM/WB integer pipeline with a load-use
// hazard unit, EX/MEM and MEM/WB forwarding, write-through regfile and data memory.
module pipe5_hazard_core #(
  parameter int DW  = 8,
  parameter int RA  = 3,
  parameter int PCW = 8,
  parameter int MA  = 4,
  parameter int IW  = 4 + 3 * RA + DW
) (
  input  logic           clk,
  input  logic           rst,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic [PCW-1:0] pc,
  output logic           stall,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b,
  output logic           wb_valid,
  output logic [RA-1:0]  wb_rd,
  output logic [DW-1:0]  wb_data
);

  localparam int NREG = 1 << RA;
  localparam int NMEM = 1 << MA;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] instr;
  } ifid_t;

  // Decoded flags are already qualified by valid, so a bubble never matches.
  typedef struct packed {
    logic          valid;
    logic [3:0]    op;
    logic [RA-1:0] rs1;
    logic [RA-1:0] rs2;
    logic [RA-1:0] rd;
    logic          use1;
    logic          use2;
    logic          wr;
    logic          ld;
    logic          st;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic          ld;
    logic          st;
    logic [RA-1:0] rd;
    logic [DW-1:0] res;
    logic [DW-1:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [RA-1:0] rd;
    logic [DW-1:0] data;
  } memwb_t;

  logic [PCW-1:0] pc_q, pc_d;
  ifid_t          ifid_q, ifid_d;
  idex_t          idex_q, idex_d;
  exmem_t         exmem_q, exmem_d;
  memwb_t         memwb_q, memwb_d;
  logic [DW-1:0]  rf_q   [NREG];
  logic [DW-1:0]  rf_d   [NREG];
  logic [DW-1:0]  dmem_q [NMEM];
  logic [DW-1:0]  dmem_d [NMEM];

  // ---------------- ID: decode, regfile read with WB bypass, hazard ----------
  logic [3:0]    id_op;
  logic [RA-1:0] id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_imm, id_a, id_b;
  logic          id_use1, id_use2, id_wr;
  logic          stall_c;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path can leave it holding a value and infer a latch.
  always_comb begin
    id_op   = ifid_q.instr[IW-1 -: 4];
    id_rs1  = ifid_q.instr[IW-5 -: RA];
    id_rs2  = ifid_q.instr[IW-5-RA -: RA];
    id_rd   = ifid_q.instr[IW-5-2*RA -: RA];
    id_imm  = ifid_q.instr[DW-1:0];
    id_use1 = ifid_q.valid && (id_op >= OP_ADD) && (id_op <= OP_ST);
    id_use2 = ifid_q.valid && (((id_op >= OP_ADD) && (id_op <= OP_XOR)) || (id_op == OP_ST));
    id_wr   = ifid_q.valid && (id_op >= OP_ADD) && (id_op <= OP_LD) && (id_rd != '0);

    id_a = rf_q[id_rs1];
    id_b = rf_q[id_rs2];
    if (wb_valid && (wb_rd == id_rs1)) id_a = wb_data;
    if (wb_valid && (wb_rd == id_rs2)) id_b = wb_data;

    stall_c = idex_q.valid && idex_q.ld && idex_q.wr &&
              ((id_use1 && (id_rs1 == idex_q.rd)) || (id_use2 && (id_rs2 == idex_q.rd)));
  end

  always_comb begin
    pc_d   = stall_c ? pc_q : pc_q + 1'b1;
    ifid_d = ifid_q;
    if (!stall_c) begin
      ifid_d.valid = 1'b1;
      ifid_d.instr = imem_data;
    end

    idex_d = '0;
    if (!stall_c) begin
      idex_d.valid = ifid_q.valid;
      idex_d.op    = id_op;
      idex_d.rs1   = id_rs1;
      idex_d.rs2   = id_rs2;
      idex_d.rd    = id_rd;
      idex_d.use1  = id_use1;
      idex_d.use2  = id_use2;
      idex_d.wr    = id_wr;
      idex_d.ld    = ifid_q.valid && (id_op == OP_LD);
      idex_d.st    = ifid_q.valid && (id_op == OP_ST);
      idex_d.a     = id_a;
      idex_d.b     = id_b;
      idex_d.imm   = id_imm;
    end
  end

  // ---------------- EX: forwarding select and ALU ----------------------------
  logic [1:0]    sel_a, sel_b;
  logic [DW-1:0] ex_a, ex_b, ex_res;

  always_comb begin
    sel_a = FWD_IDEX;
    sel_b = FWD_IDEX;
    // A load in EX/MEM has no data yet; the stall keeps its consumer out of EX.
    if (idex_q.use1) begin
      if (exmem_q.valid && exmem_q.wr && !exmem_q.ld && (exmem_q.rd == idex_q.rs1))
        sel_a = FWD_EXMEM;
      else if (memwb_q.valid && memwb_q.wr && (memwb_q.rd == idex_q.rs1))
        sel_a = FWD_MEMWB;
    end
    if (idex_q.use2) begin
      if (exmem_q.valid && exmem_q.wr && !exmem_q.ld && (exmem_q.rd == idex_q.rs2))
        sel_b = FWD_EXMEM;
      else if (memwb_q.valid && memwb_q.wr && (memwb_q.rd == idex_q.rs2))
        sel_b = FWD_MEMWB;
    end

    case (sel_a)
      FWD_EXMEM: ex_a = exmem_q.res;
      FWD_MEMWB: ex_a = memwb_q.data;
      default:   ex_a = idex_q.a;
    endcase
    case (sel_b)
      FWD_EXMEM: ex_b = exmem_q.res;
      FWD_MEMWB: ex_b = memwb_q.data;
      default:   ex_b = idex_q.b;
    endcase

    case (idex_q.op)
      OP_ADD:                ex_res = ex_a + ex_b;
      OP_SUB:                ex_res = ex_a - ex_b;
      OP_AND:                ex_res = ex_a & ex_b;
      OP_OR:                 ex_res = ex_a | ex_b;
      OP_XOR:                ex_res = ex_a ^ ex_b;
      OP_ADDI, OP_LD, OP_ST: ex_res = ex_a + idex_q.imm;
      default:               ex_res = '0;
    endcase

    exmem_d.valid = idex_q.valid;
    exmem_d.wr    = idex_q.wr;
    exmem_d.ld    = idex_q.ld;
    exmem_d.st    = idex_q.st;
    exmem_d.rd    = idex_q.rd;
    exmem_d.res   = ex_res;
    exmem_d.sdata = ex_b;
  end

  // ---------------- MEM: combinational read, store at end of cycle ----------
  logic [MA-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  always_comb begin
    mem_addr  = exmem_q.res[MA-1:0];
    mem_rdata = dmem_q[mem_addr];
    dmem_d    = dmem_q;
    if (exmem_q.valid && exmem_q.st) dmem_d[mem_addr] = exmem_q.sdata;

    memwb_d.valid = exmem_q.valid;
    memwb_d.wr    = exmem_q.valid && exmem_q.wr;
    memwb_d.rd    = exmem_q.rd;
    memwb_d.data  = exmem_q.ld ? mem_rdata : exmem_q.res;
  end

  // ---------------- WB -------------------------------------------------------
  always_comb begin
    rf_d = rf_q;
    if (wb_valid) rf_d[wb_rd] = wb_data;
  end

  assign wb_valid  = memwb_q.valid && memwb_q.wr;
  assign wb_rd     = memwb_q.rd;
  assign wb_data   = memwb_q.data;
  assign stall     = stall_c;
  assign fwd_a     = sel_a;
  assign fwd_b     = sel_b;
  assign pc        = pc_q;
  assign imem_addr = pc_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      // NOTE: the regfile and data memory are cleared on reset like any other
      // flop; both are small arrays and a zeroed state is part of the contract.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      for (int i = 0; i < NMEM; i++) dmem_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      rf_q    <= rf_d;
      dmem_q  <= dmem_d;
    end
  end

endmodule

// File: tb/tb_pipe5_hazard_core.sv
// Self-checking bench for pipe5_hazard_core: a sequential ISA model plus a slot
// stream (instructions with load-use bubbles) predicts every cycle's outputs.
module tb_pipe5_hazard_core;

  localparam int DW   = 8;
  localparam int RA   = 3;
  localparam int PCW  = 8;
  localparam int MA   = 4;
  localparam int IW   = 4 + 3 * RA + DW;
  localparam int NREG = 1 << RA;
  localparam int NMEM = 1 << MA;
  localparam int ROMN = 1 << PCW;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                         XOR_ = 4'd5, ADDI = 4'd6, LD = 4'd7, ST = 4'd8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [PCW-1:0] imem_addr, pc;
  logic [IW-1:0]  imem_data;
  logic           stall, wb_valid;
  logic [1:0]     fwd_a, fwd_b;
  logic [RA-1:0]  wb_rd;
  logic [DW-1:0]  wb_data;

  logic [IW-1:0] rom [ROMN];
  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  pipe5_hazard_core #(.DW(DW), .RA(RA), .PCW(PCW), .MA(MA)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct { int cyc; logic [RA-1:0] rd; logic [DW-1:0] data; } wb_exp_t;
  typedef struct { logic stall; logic [1:0] fa; logic [1:0] fb; logic [PCW-1:0] pc; } cyc_exp_t;

  wb_exp_t  wb_q [$];
  cyc_exp_t cyc_q[$];
  int       slots[$];   // ROM index per pipeline slot, -1 for an inserted bubble

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input logic [3:0] op, input logic [RA-1:0] rs1,
                                        input logic [RA-1:0] rs2, input logic [RA-1:0] rd,
                                        input logic [DW-1:0] imm);
    return {op, rs1, rs2, rd, imm};
  endfunction

  function automatic logic [3:0]    f_op (input logic [IW-1:0] i); return i[IW-1 -: 4];         endfunction
  function automatic logic [RA-1:0] f_rs1(input logic [IW-1:0] i); return i[IW-5 -: RA];        endfunction
  function automatic logic [RA-1:0] f_rs2(input logic [IW-1:0] i); return i[IW-5-RA -: RA];     endfunction
  function automatic logic [RA-1:0] f_rd (input logic [IW-1:0] i); return i[IW-5-2*RA -: RA];   endfunction
  function automatic logic [DW-1:0] f_imm(input logic [IW-1:0] i); return i[DW-1:0];            endfunction

  function automatic bit uses1(input logic [IW-1:0] i); return f_op(i) >= ADD && f_op(i) <= ST; endfunction
  function automatic bit uses2(input logic [IW-1:0] i);
    return (f_op(i) >= ADD && f_op(i) <= XOR_) || f_op(i) == ST;
  endfunction
  function automatic bit writes(input logic [IW-1:0] i);
    return f_op(i) >= ADD && f_op(i) <= LD && f_rd(i) != '0;
  endfunction

  function automatic bit load_use(input logic [IW-1:0] prev, input logic [IW-1:0] cur);
    if (f_op(prev) != LD || !writes(prev)) return 1'b0;
    return (uses1(cur) && f_rs1(cur) == f_rd(prev)) || (uses2(cur) && f_rs2(cur) == f_rd(prev));
  endfunction

  // Operand source for the instruction in slot s: the slot just ahead wins unless
  // it is a load, then the slot two ahead, otherwise the value read in ID.
  function automatic logic [1:0] fwd_for(input int s, input logic [RA-1:0] src);
    logic [IW-1:0] p;
    if (s >= 1 && slots[s-1] >= 0) begin
      p = rom[slots[s-1] % ROMN];
      if (writes(p) && f_op(p) != LD && f_rd(p) == src) return 2'b10;
    end
    if (s >= 2 && slots[s-2] >= 0) begin
      p = rom[slots[s-2] % ROMN];
      if (writes(p) && f_rd(p) == src) return 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic build_model(input int ncyc);
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] mem  [NMEM];
    logic [IW-1:0] ins;
    logic [DW-1:0] a, b, ea, res;
    cyc_exp_t      ce;
    wb_exp_t       we;
    int            j, nb;
    slots.delete();
    cyc_q.delete();
    wb_q.delete();
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    for (int i = 0; i < NMEM; i++) mem[i] = '0;
    j = 0;
    while (slots.size() < ncyc) begin
      if (j > 0 && load_use(rom[(j-1) % ROMN], rom[j % ROMN])) slots.push_back(-1);
      slots.push_back(j);
      j++;
    end
    for (int s = 0; s < slots.size(); s++) begin
      if (slots[s] >= 0) begin
        ins = rom[slots[s] % ROMN];
        a   = regs[f_rs1(ins)];
        b   = regs[f_rs2(ins)];
        ea  = a + f_imm(ins);
        case (f_op(ins))
          ADD:     res = a + b;
          SUB:     res = a - b;
          AND_:    res = a & b;
          OR_:     res = a | b;
          XOR_:    res = a ^ b;
          ADDI:    res = ea;
          LD:      res = mem[ea[MA-1:0]];
          default: res = '0;
        endcase
        if (f_op(ins) == ST) mem[ea[MA-1:0]] = b;
        if (writes(ins)) begin
          regs[f_rd(ins)] = res;
          if (s + 4 < ncyc) begin
            we.cyc  = s + 4;
            we.rd   = f_rd(ins);
            we.data = res;
            wb_q.push_back(we);
          end
        end
      end
    end
    nb = 0;
    for (int t = 0; t < ncyc; t++) begin
      ce.stall = 1'b0;
      ce.fa    = 2'b00;
      ce.fb    = 2'b00;
      if (t >= 1) ce.stall = (slots[t-1] < 0);
      if (t >= 2) begin
        if (slots[t-2] < 0) nb++;
        else begin
          ins = rom[slots[t-2] % ROMN];
          if (uses1(ins)) ce.fa = fwd_for(t - 2, f_rs1(ins));
          if (uses2(ins)) ce.fb = fwd_for(t - 2, f_rs2(ins));
        end
      end
      ce.pc = PCW'(t - nb);
      cyc_q.push_back(ce);
    end
  endtask

  // Monitor: one cycle expectation per sampled cycle, one retirement per wb_valid.
  cyc_exp_t mce;
  wb_exp_t  mwe;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc_q.size() == 0) check("cycle_expectation_available", 32'd0, 32'd1);
      else begin
        mce = cyc_q.pop_front();
        check("stall", 32'(stall), 32'(mce.stall));
        check("fwd_a", 32'(fwd_a), 32'(mce.fa));
        check("fwd_b", 32'(fwd_b), 32'(mce.fb));
        check("pc",    32'(pc),    32'(mce.pc));
        check("imem_addr", 32'(imem_addr), 32'(mce.pc));
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("unexpected_wb_valid", 32'd1, 32'd0);
        else begin
          mwe = wb_q.pop_front();
          check("wb_cycle", 32'(cyc), 32'(mwe.cyc));
          check("wb_rd",    32'(wb_rd), 32'(mwe.rd));
          check("wb_data",  32'(wb_data), 32'(mwe.data));
        end
      end
      cyc++;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < ROMN; i++) rom[i] = '0;
  endtask

  // Assert reset in the middle of a cycle and check outputs before any edge.
  task automatic reset_check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_pc",       32'(pc),       32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd",    32'(wb_rd),    32'd0);
    check("rst_wb_data",  32'(wb_data),  32'd0);
    check("rst_stall",    32'(stall),    32'd0);
    check("rst_fwd_a",    32'(fwd_a),    32'd0);
    check("rst_fwd_b",    32'(fwd_b),    32'd0);
  endtask

  task automatic run_window(input int ncyc);
    build_model(ncyc);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc    = 0;
    mon_en = 1'b1;
    repeat (ncyc) @(negedge clk);
    #1 mon_en = 1'b0;
    check("wb_queue_drained",  32'(wb_q.size()),  32'd0);
    check("cyc_queue_drained", 32'(cyc_q.size()), 32'd0);
  endtask

  task automatic rand_program(input int len);
    int r;
    clear_rom();
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 19);
      rom[i] = enc((r >= 16) ? LD : 4'(r), RA'($urandom_range(0, 3)), RA'($urandom_range(0, 3)),
                   RA'($urandom_range(0, 3)), DW'($urandom));
    end
  endtask

  initial begin
    clear_rom();

    // Independent ops.
    reset_check();
    clear_rom();
    rom[0] = enc(ADDI, 3'd0, 3'd0, 3'd1, 8'd5);
    rom[1] = enc(ADDI, 3'd0, 3'd0, 3'd2, 8'd3);
    rom[4] = enc(ADD,  3'd1, 3'd2, 3'd3, 8'd0);
    run_window(12);

    // EX/MEM forward.
    reset_check();
    clear_rom();
    rom[0] = enc(ADDI, 3'd0, 3'd0, 3'd1, 8'd7);
    rom[1] = enc(SUB,  3'd1, 3'd0, 3'd2, 8'd0);
    run_window(9);

    // EX/MEM priority over MEM/WB, then MEM/WB alone.
    reset_check();
    clear_rom();
    rom[0] = enc(ADDI, 3'd0, 3'd0, 3'd1, 8'd1);
    rom[1] = enc(ADDI, 3'd0, 3'd0, 3'd1, 8'd2);
    rom[2] = enc(ADD,  3'd1, 3'd1, 3'd3, 8'd0);
    run_window(10);
    reset_check();
    rom[1] = enc(NOP, 3'd0, 3'd0, 3'd0, 8'd0);
    run_window(10);

    // Store, load, then a dependent add: one stall cycle.
    reset_check();
    clear_rom();
    rom[0] = enc(ADDI, 3'd0, 3'd0, 3'd1, 8'd9);
    rom[1] = enc(ST,   3'd0, 3'd1, 3'd0, 8'd3);
    rom[2] = enc(LD,   3'd0, 3'd0, 3'd4, 8'd3);
    rom[3] = enc(ADD,  3'd4, 3'd4, 3'd5, 8'd0);
    run_window(12);

    // Writes to r0 are dropped and never forwarded.
    reset_check();
    clear_rom();
    rom[0] = enc(ADDI, 3'd0, 3'd0, 3'd0, 8'd1);
    rom[1] = enc(ADDI, 3'd0, 3'd0, 3'd1, 8'd5);
    rom[3] = enc(ADD,  3'd0, 3'd0, 3'd2, 8'd0);
    run_window(10);

    // PC wrap over an all-NOP ROM.
    reset_check();
    clear_rom();
    run_window(262);

    // Random programs; windows often end with work in flight before reset.
    for (int p = 0; p < 14; p++) begin
      reset_check();
      rand_program(40);
      run_window(30 + $urandom_range(0, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
